// File: rtl/key_pkg.sv
// Shared types and constants for the organ key debouncer: channel count,
// note index width, the per-channel debounce state encoding and a popcount helper.
package key_pkg;

    localparam int NUM_KEYS         = 8;
    localparam int NOTE_W           = 3;
    localparam int COUNT_W          = 4;
    localparam int DEBOUNCE_DEFAULT = 2000000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_KEYS-1:0] v);
        logic [COUNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            c = c + COUNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM with stability counter,
// registered level and press/release pulses. KEY_TOGGLE_EN selects latch-mode level.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter bit RAW_ACTIVE_HIGH = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_level_next,
    output logic o_press_next
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_in;
    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    deb_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_level_next;
    logic             w_press_next;
    logic             w_release_next;

    assign w_in = RAW_ACTIVE_HIGH ? i_raw : ~i_raw;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= w_in;
            r_sync2   <= r_sync1;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
        end
    end

    // The counter only advances in the two WAIT states; it sits at zero otherwise.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = HELD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_next = HELD;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
`ifdef KEY_TOGGLE_EN
        w_level_next = r_level ^ ((r_state == PRESS_WAIT) && (w_state_next == HELD));
`else
        w_level_next = (w_state_next == HELD) || (w_state_next == RELEASE_WAIT);
`endif
        w_press_next   = w_level_next & ~r_level;
        w_release_next = ~w_level_next & r_level;
    end

    assign o_level      = r_level;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_level_next = w_level_next;
    assign o_press_next = w_press_next;

endmodule

// File: rtl/key_debounce.sv
// Eight-key debouncer top: per-key channels plus last-note priority encode and
// active-key popcount. Build option KEY_TOGGLE_EN switches channels to latch mode.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter bit RAW_ACTIVE_HIGH = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NOTE_W-1:0]   last_note,
    output logic                last_valid,
    output logic [COUNT_W-1:0]  active_count
);

    logic [NUM_KEYS-1:0] w_level_next;
    logic [NUM_KEYS-1:0] w_press_next;
    logic [NOTE_W-1:0]   w_note_next;
    logic [COUNT_W-1:0]  w_count_next;
    logic [NOTE_W-1:0]   r_last_note;
    logic                r_last_valid;
    logic [COUNT_W-1:0]  r_count;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RAW_ACTIVE_HIGH (RAW_ACTIVE_HIGH)
            ) u_ch (
                .i_clk        (sys_clk),
                .i_rst        (sys_rst),
                .i_raw        (key_raw[gi]),
                .o_level      (key_level[gi]),
                .o_press      (key_press[gi]),
                .o_release    (key_release[gi]),
                .o_level_next (w_level_next[gi]),
                .o_press_next (w_press_next[gi])
            );
        end
    endgenerate

    // Ascending scan so the highest simultaneously pressed index wins.
    always_comb begin
        w_note_next = r_last_note;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_press_next[i]) begin
                w_note_next = NOTE_W'(i);
            end
        end
        w_count_next = popcount(w_level_next);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_last_note  <= '0;
            r_last_valid <= 1'b0;
            r_count      <= '0;
        end else begin
            r_last_note <= w_note_next;
            r_count     <= w_count_next;
            if (|w_press_next) begin
                r_last_valid <= 1'b1;
            end else if (w_count_next == '0) begin
                r_last_valid <= 1'b0;
            end
        end
    end

    assign last_note    = r_last_note;
    assign last_valid   = r_last_valid;
    assign active_count = r_count;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=16; pulse events are scored against
// an expected queue of {cycle, press, release, level, note, valid, count} records.
module tb_key_debounce;

    localparam int DEB = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] key_raw;
    logic [7:0] key_level;
    logic [7:0] key_press;
    logic [7:0] key_release;
    logic [2:0] last_note;
    logic       last_valid;
    logic [3:0] active_count;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [47:0] exp_q[$];
    logic [47:0] w_rec;

    key_debounce #(.DEBOUNCE_CYCLES(DEB)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_raw      (key_raw),
        .key_level    (key_level),
        .key_press    (key_press),
        .key_release  (key_release),
        .last_note    (last_note),
        .last_valid   (last_valid),
        .active_count (active_count)
    );

    // clock/reset block
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic drive(input int idx, input logic v);
        key_raw[idx] = v;
    endtask

    // Raw change driven at this negedge: the level moves at edge +DEB+3.
    task automatic expect_event(input logic [7:0] p, input logic [7:0] r, input logic [7:0] lvl,
                                input logic [2:0] note, input logic valid, input logic [3:0] cnt);
        int t;
        t = cyc + DEB + 3;
        exp_q.push_back({t[15:0], p, r, lvl, note, valid, cnt});
    endtask

    // scoreboard
    assign w_rec = {cyc[15:0], key_press, key_release, key_level, last_note, last_valid, active_count};

    always @(negedge sys_clk) begin
        if ((key_press | key_release) != 8'h00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'(w_rec), 64'h0);
            end else begin
                check("event", 64'(w_rec), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        sys_rst = 1'b1;
        key_raw = 8'h00;
        idle(3);
        check("rst_level", 64'(key_level), 64'h0);
        check("rst_pulses", 64'({key_press, key_release}), 64'h0);
        check("rst_note_valid_cnt", 64'({last_note, last_valid, active_count}), 64'h0);
        sys_rst = 1'b0;
`ifdef KEY_TOGGLE_EN
        drive(4, 1'b1); expect_event(8'h10, 8'h00, 8'h10, 3'd4, 1'b1, 4'd1); idle(25);
        drive(4, 1'b0); idle(40);
        check("tgl_hold", 64'({key_level, active_count}), 64'({8'h10, 4'd1}));
        drive(4, 1'b1); expect_event(8'h00, 8'h10, 8'h00, 3'd4, 1'b0, 4'd0); idle(25);
        drive(4, 1'b0); idle(40);
        check("tgl_off", 64'({key_level, active_count}), 64'h0);
`else
        // single press: level must not move before edge DEB+3
        drive(3, 1'b1); expect_event(8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 4'd1);
        idle(DEB + 2);
        check("p3_not_early", 64'(key_level), 64'h0);
        idle(7);
        check("p3_level", 64'({key_level, key_press}), 64'({8'h08, 8'h00}));

        // glitches of 10 and DEB cycles are rejected; DEB+1 cycles is accepted
        foreach (exp_q[i]) check("q_drained", 64'(exp_q.size()), 64'h0);
        for (int k = 10; k <= DEB; k += DEB - 10) begin
            drive(5, 1'b1); idle(k); drive(5, 1'b0); idle(30);
        end
        check("glitch_out", 64'({key_level, last_note, active_count}), 64'({8'h08, 3'd3, 4'd1}));
        check("glitch_idle", 64'(dut.g_ch[5].u_ch.r_state), 64'h0);
        drive(7, 1'b1); expect_event(8'h80, 8'h00, 8'h88, 3'd7, 1'b1, 4'd2);
        idle(DEB + 1);
        drive(7, 1'b0); expect_event(8'h00, 8'h80, 8'h08, 3'd7, 1'b1, 4'd1);
        idle(25);

        // release to zero clears valid, note holds
        drive(3, 1'b0); expect_event(8'h00, 8'h08, 8'h00, 3'd7, 1'b0, 4'd0); idle(25);

        // simultaneous presses: highest index wins
        drive(1, 1'b1); drive(6, 1'b1);
        expect_event(8'h42, 8'h00, 8'h42, 3'd6, 1'b1, 4'd2); idle(25);
        drive(6, 1'b0); expect_event(8'h00, 8'h40, 8'h02, 3'd6, 1'b1, 4'd1); idle(25);
        drive(1, 1'b0); expect_event(8'h00, 8'h02, 8'h00, 3'd6, 1'b0, 4'd0); idle(25);
        check("note_hold", 64'({last_note, last_valid}), 64'({3'd6, 1'b0}));

        // press on 4 and release on 2 in the same cycle
        drive(2, 1'b1); expect_event(8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 4'd1); idle(25);
        drive(2, 1'b0); drive(4, 1'b1);
        expect_event(8'h10, 8'h04, 8'h10, 3'd4, 1'b1, 4'd1); idle(25);

        // key 0 held through bounces shorter than the debounce window
        drive(0, 1'b1); expect_event(8'h01, 8'h00, 8'h11, 3'd0, 1'b1, 4'd2); idle(25);
        repeat (5) begin
            drive(0, 1'b0); idle(8); drive(0, 1'b1); idle(4);
        end
        idle(20);
        check("bounce_level", 64'({key_level, active_count}), 64'({8'h11, 4'd2}));

        // reset while keys 0, 2, 4 held: silent clear, then re-acceptance
        drive(2, 1'b1); expect_event(8'h04, 8'h00, 8'h15, 3'd2, 1'b1, 4'd3); idle(25);
        sys_rst = 1'b1;
        idle(1);
        sys_rst = 1'b0;
        check("mid_rst_level", 64'({key_level, key_press, key_release}), 64'h0);
        check("mid_rst_misc", 64'({last_note, last_valid, active_count}), 64'h0);
        expect_event(8'h15, 8'h00, 8'h15, 3'd4, 1'b1, 4'd3);
        idle(DEB + 2);
        check("rst_not_early", 64'(key_level), 64'h0);
        idle(7);
        key_raw = 8'h00;
        expect_event(8'h00, 8'h15, 8'h00, 3'd4, 1'b0, 4'd0);
        idle(30);
        check("final_level", 64'({key_level, active_count, last_note}), 64'({8'h00, 4'd0, 3'd4}));
`endif
        idle(10);
        check("q_empty", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
